// File: rtl/tpu_window_streamer.sv
// Activation buffer plus window streamer: walks KxK(xC) windows over a square ifmap in raster order.
// Optional zero padding (P = K/2) is enabled by defining TPU_WINDOW_ZERO_PAD_EN.
module tpu_window_streamer #(
    parameter int dataSize      = 8,
    parameter int numInChannel  = 1,
    parameter int kernelWidth   = 3,
    parameter int numRegister   = 256,
    localparam int numAddrBuffer = $clog2(numRegister)
) (
    input  logic                                                       clk,
    input  logic                                                       nrst,
    input  logic                                                       wr_en,
    input  logic [numAddrBuffer-1:0]                                   wr_addr,
    input  logic [dataSize-1:0]                                        wr_data,
    input  logic [15:0]                                                cfg_ifmap_width,
    input  logic [1:0]                                                 cfg_stride,
    input  logic                                                       ctrl_start,
    output logic [kernelWidth*kernelWidth*numInChannel*dataSize-1:0]   window_out,
    output logic                                                       out_valid,
    input  logic                                                       out_ready,
    output logic                                                       flag_busy,
    output logic                                                       flag_done
);
    localparam int K   = kernelWidth;
    localparam int E   = K * K * numInChannel;
    localparam int EW  = (E > 1) ? $clog2(E) : 1;
    localparam int KW  = $clog2(K + 1);
    localparam int CW  = (numInChannel > 1) ? $clog2(numInChannel) : 1;
    localparam int AW1 = numAddrBuffer + 1;
`ifdef TPU_WINDOW_ZERO_PAD_EN
    localparam int P = K / 2;
    localparam logic [16:0] P17 = 17'(P);
`else
    localparam int P = 0;
`endif
    localparam logic [17:0]    K18       = 18'(K);
    localparam logic [17:0]    P2_18     = 18'(2 * P);
    localparam logic [EW-1:0]  E_LAST    = EW'(E - 1);
    localparam logic [KW-1:0]  K_LAST    = KW'(K - 1);
    localparam logic [CW-1:0]  C_LAST    = CW'(numInChannel - 1);
    localparam logic [63:0]    NUM_REG64 = 64'(numRegister);
    localparam logic [63:0]    C64       = 64'(numInChannel);
    localparam logic [AW1-1:0] REG_LIM   = AW1'(numRegister);

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, EMIT = 2'd2, DONE = 2'd3} state_t;
    state_t state_r, state_next_s;

    logic [dataSize-1:0]         mem_r [numRegister];
    logic [E-1:0][dataSize-1:0]  win_r;
    logic [15:0]                 w_r;
    logic [1:0]                  s_r;
    logic [15:0]                 ox_r, oy_r;
    logic [KW-1:0]               kx_r, ky_r;
    logic [CW-1:0]               ch_r;
    logic [EW-1:0]               elem_r;
    logic                        out_valid_r, flag_busy_r, flag_done_r;
    logic                        out_valid_s, flag_busy_s, flag_done_s;
    logic [17:0]                 span_s, cfg_span_s;
    logic                        more_x_s, more_y_s, last_win_s;
    logic [16:0]                 prow_s, pcol_s, row_s, col_s;
    logic                        inb_s;
    logic [63:0]                 addr_s;
    logic [dataSize-1:0]         rd_data_s;

    // Origins live in padded coordinates; a next origin exists while it still fits inside W+2P.
    assign span_s     = {2'b00, w_r} + P2_18;
    assign cfg_span_s = {2'b00, cfg_ifmap_width} + P2_18;
    assign more_x_s   = ({2'b00, ox_r} + {16'd0, s_r} + K18) <= span_s;
    assign more_y_s   = ({2'b00, oy_r} + {16'd0, s_r} + K18) <= span_s;
    assign last_win_s = !more_x_s && !more_y_s;

    assign window_out = win_r;
    assign out_valid  = out_valid_r;
    assign flag_busy  = flag_busy_r;
    assign flag_done  = flag_done_r;

    // Buffer write port, only open while idle; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en && (state_r == IDLE) && ({1'b0, wr_addr} < REG_LIM)) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Element address for the current fetch position, with out-of-range reads returning zero.
    always_comb begin
        prow_s = {1'b0, oy_r} + 17'(ky_r);
        pcol_s = {1'b0, ox_r} + 17'(kx_r);
`ifdef TPU_WINDOW_ZERO_PAD_EN
        inb_s = (prow_s >= P17) && (prow_s < ({1'b0, w_r} + P17)) &&
                (pcol_s >= P17) && (pcol_s < ({1'b0, w_r} + P17));
        row_s = prow_s - P17;
        col_s = pcol_s - P17;
`else
        inb_s = 1'b1;
        row_s = prow_s;
        col_s = pcol_s;
`endif
        addr_s = ((64'(row_s) * 64'(w_r)) + 64'(col_s)) * C64 + 64'(ch_r);
        if (inb_s && (addr_s < NUM_REG64)) begin
            rd_data_s = mem_r[addr_s[numAddrBuffer-1:0]];
        end else begin
            rd_data_s = '0;
        end
    end

    // State register and registered status outputs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            flag_busy_r <= 1'b0;
            flag_done_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= out_valid_s;
            flag_busy_r <= flag_busy_s;
            flag_done_r <= flag_done_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (ctrl_start) begin
                    state_next_s = (cfg_span_s < K18) ? DONE : FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                state_next_s = (elem_r == E_LAST) ? EMIT : FETCH;
            end
            EMIT: begin
                if (out_ready) begin
                    state_next_s = last_win_s ? DONE : FETCH;
                end else begin
                    state_next_s = EMIT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Status decode of the upcoming state so the registered flags line up with state_r.
    always_comb begin
        out_valid_s = 1'b0;
        flag_busy_s = 1'b0;
        flag_done_s = 1'b0;
        case (state_next_s)
            IDLE:  flag_busy_s = 1'b0;
            FETCH: flag_busy_s = 1'b1;
            EMIT: begin
                out_valid_s = 1'b1;
                flag_busy_s = 1'b1;
            end
            DONE: begin
                flag_done_s = 1'b1;
                flag_busy_s = 1'b1;
            end
            default: begin
                out_valid_s = 1'b0;
                flag_busy_s = 1'b0;
                flag_done_s = 1'b0;
            end
        endcase
    end

    // Window assembly, kernel walk counters and origin stepping.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            win_r  <= '0;
            w_r    <= '0;
            s_r    <= '0;
            ox_r   <= '0;
            oy_r   <= '0;
            kx_r   <= '0;
            ky_r   <= '0;
            ch_r   <= '0;
            elem_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ctrl_start) begin
                        w_r    <= cfg_ifmap_width;
                        s_r    <= (cfg_stride == 2'd0) ? 2'd1 : cfg_stride;
                        ox_r   <= '0;
                        oy_r   <= '0;
                        kx_r   <= '0;
                        ky_r   <= '0;
                        ch_r   <= '0;
                        elem_r <= '0;
                    end
                end
                FETCH: begin
                    win_r[elem_r] <= rd_data_s;
                    if (elem_r == E_LAST) begin
                        elem_r <= '0;
                        ch_r   <= '0;
                        kx_r   <= '0;
                        ky_r   <= '0;
                    end else begin
                        elem_r <= elem_r + EW'(1);
                        if (ch_r == C_LAST) begin
                            ch_r <= '0;
                            if (kx_r == K_LAST) begin
                                kx_r <= '0;
                                ky_r <= ky_r + KW'(1);
                            end else begin
                                kx_r <= kx_r + KW'(1);
                            end
                        end else begin
                            ch_r <= ch_r + CW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (more_x_s) begin
                            ox_r <= ox_r + {14'd0, s_r};
                        end else begin
                            ox_r <= '0;
                            oy_r <= oy_r + {14'd0, s_r};
                        end
                    end
                end
                default: begin
                    elem_r <= '0;
                end
            endcase
        end
    end
endmodule
